// File: rtl/mem_access_unit.sv
`default_nettype none
// mem_access_unit: single-outstanding CPU load/store sequencer with local lane select/extend.
// Optional MEM_ALIGN_CHECK_EN: flag misaligned W/H accesses and answer them without touching memory.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_mt,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic        mem_ld,
  output logic        mem_wr,
  output logic [2:0]  mem_mt,
  input  logic        mem_busy
);

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        misaligned;
  logic [2:0]  mt_norm;
  logic [31:0] wdata_rep;
  logic [31:0] addr_r;
  logic [2:0]  acc_mt_r;
  logic        write_r;
  logic [31:0] wdata_r;
  logic [2:0]  mem_mt_r;
  logic [31:0] rdata_r;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    mt_norm = MT_W;
    case (req_mt)
      MT_B, MT_H, MT_W, MT_BU, MT_HU: mt_norm = req_mt;
      default:                        mt_norm = MT_W;
    endcase
  end

  always_comb begin
    wdata_rep = req_wdata;
    case (mt_norm)
      MT_H, MT_HU: wdata_rep = {2{req_wdata[15:0]}};
      MT_B, MT_BU: wdata_rep = {4{req_wdata[7:0]}};
      default:     wdata_rep = req_wdata;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_r;

  always_comb begin
    misaligned = 1'b0;
    case (mt_norm)
      MT_W:        misaligned = |req_addr[1:0];
      MT_H, MT_HU: misaligned = req_addr[0];
      default:     misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    mis_r <= 1'b0;
    else if (accept) mis_r <= misaligned;
  end

  assign resp_misaligned = mis_r;
`else
  assign misaligned      = 1'b0;
  assign resp_misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_ld     = 1'b0;
    mem_wr     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = misaligned ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_ld    = 1'b1;
        mem_wr    = write_r;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        mem_wr = write_r;
        if (mem_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        mem_wr = write_r;
        if (!mem_busy) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (addr_r[1:0])
      2'd0:    byte_sel = mem_data_in[7:0];
      2'd1:    byte_sel = mem_data_in[15:8];
      2'd2:    byte_sel = mem_data_in[23:16];
      default: byte_sel = mem_data_in[31:24];
    endcase
    half_sel = addr_r[1] ? mem_data_in[31:16] : mem_data_in[15:0];
    case (acc_mt_r)
      MT_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      MT_BU:   load_ext = {24'd0, byte_sel};
      MT_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      MT_HU:   load_ext = {16'd0, half_sel};
      default: load_ext = mem_data_in;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r   <= 32'd0;
      acc_mt_r <= 3'd0;
      write_r  <= 1'b0;
      wdata_r  <= 32'd0;
      mem_mt_r <= 3'd0;
      rdata_r  <= 32'd0;
    end else begin
      if (accept) begin
        addr_r   <= req_addr;
        acc_mt_r <= mt_norm;
        write_r  <= req_write;
        wdata_r  <= wdata_rep;
        mem_mt_r <= req_write ? mt_norm : MT_W;
        if (misaligned) rdata_r <= 32'd0;
      end
      if (state == WAIT_DONE && !mem_busy) rdata_r <= write_r ? 32'd0 : load_ext;
    end
  end

  assign mem_address  = addr_r;
  assign mem_data_out = wdata_r;
  assign mem_mt       = mem_mt_r;
  assign resp_rdata   = rdata_r;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// tb_mem_access_unit: randomized scoreboard bench; reference model plus a simple bus memory.
module tb_mem_access_unit;

  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [2:0]  req_mt = 3'd0;
  logic        req_ready, resp_valid, resp_misaligned;
  logic [31:0] resp_rdata, mem_address, mem_data_out;
  logic [31:0] mem_data_in = 32'd0;
  logic        mem_ld, mem_wr;
  logic [2:0]  mem_mt;
  logic        mem_busy = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_mt(req_mt), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_address(mem_address), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_ld(mem_ld), .mem_wr(mem_wr), .mem_mt(mem_mt), .mem_busy(mem_busy)
  );

  typedef struct packed { logic [31:0] rdata; logic mis; } resp_t;
  typedef struct packed { logic [31:0] addr; logic [2:0] mt; logic wr; logic [31:0] data; } bus_t;

  resp_t       resp_q[$];
  bus_t        bus_q[$];
  logic [31:0] ref_mem [16];
  logic [31:0] bus_mem [16];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] norm(input logic [2:0] mt);
    return (mt inside {MT_B, MT_H, MT_W, MT_BU, MT_HU}) ? mt : MT_W;
  endfunction

  function automatic bit is_mis(input logic [2:0] mt, input logic [31:0] a);
    bit m;
    m = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (norm(mt) == MT_W) m = (a[1:0] != 2'd0);
    if (norm(mt) == MT_H || norm(mt) == MT_HU) m = a[0];
`endif
    return m;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] mt);
    logic [31:0] w, v;
    w = ref_mem[a[5:2]];
    v = w;
    case (norm(mt))
      MT_B:  begin v = w >> (8 * int'(a[1:0])); v = {{24{v[7]}}, v[7:0]}; end
      MT_BU: begin v = w >> (8 * int'(a[1:0])); v = {24'd0, v[7:0]}; end
      MT_H:  begin v = w >> (16 * int'(a[1])); v = {{16{v[15]}}, v[15:0]}; end
      MT_HU: begin v = w >> (16 * int'(a[1])); v = {16'd0, v[15:0]}; end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] mt, input logic [31:0] wd);
    case (norm(mt))
      MT_B, MT_BU: ref_mem[a[5:2]][8 * int'(a[1:0]) +: 8] = wd[7:0];
      MT_H, MT_HU: ref_mem[a[5:2]][16 * int'(a[1]) +: 16] = wd[15:0];
      default:     ref_mem[a[5:2]] = wd;
    endcase
  endtask

  function automatic logic [31:0] bus_data(input logic [2:0] mt, input logic [31:0] wd);
    case (norm(mt))
      MT_B, MT_BU: return {4{wd[7:0]}};
      MT_H, MT_HU: return {2{wd[15:0]}};
      default:     return wd;
    endcase
  endfunction

  task automatic wait_ready();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    chk("ready_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [2:0] mt, input logic [31:0] wd);
    resp_t r;
    bus_t  b;
    bit    mis, got;
    int    lat;
    mis     = is_mis(mt, a);
    r.mis   = mis;
    r.rdata = (wr || mis) ? 32'd0 : exp_load(a, mt);
    if (!mis) begin
      b.addr = a; b.wr = wr; b.mt = wr ? norm(mt) : MT_W; b.data = bus_data(mt, wd);
      bus_q.push_back(b);
      if (wr) ref_store(a, mt, wd);
    end
    resp_q.push_back(r);
    wait_ready();
    req_valid = 1'b1; req_write = wr; req_addr = a; req_mt = mt; req_wdata = wd;
    @(posedge clk);
    #1;
    // Keep a junk request asserted while busy; it must be ignored.
    req_write = 1'($urandom); req_addr = $urandom; req_mt = 3'($urandom); req_wdata = $urandom;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = resp_valid;
    end
    req_valid = 1'b0;
    chk("resp_timeout", {31'd0, got}, 32'd1);
    if (got) chk(mis ? "lat_mis" : "lat_min", {31'd0, (mis ? lat == 1 : lat >= 4)}, 32'd1);
    else begin resp_q.delete(); bus_q.delete(); end
  endtask

  // Response monitor.
  logic  prev_rv = 1'b0;
  resp_t mon_r;
  always @(negedge clk) begin
    if (resp_valid) begin
      chk("resp_pulse", {31'd0, prev_rv}, 32'd0);
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp actual=resp_valid expected=none t=%0t", $time);
      end else begin
        mon_r = resp_q.pop_front();
        chk("rdata", resp_rdata, mon_r.rdata);
        chk("misaligned", {31'd0, resp_misaligned}, {31'd0, mon_r.mis});
      end
    end
    prev_rv = resp_valid;
  end

  // Bus-side memory with random acknowledge delay and busy length.
  logic [31:0] m_a, m_d;
  logic [2:0]  m_mt;
  logic        m_w;
  int          m_dly, m_len;
  bit          m_ok;
  bus_t        m_e;
  always begin
    @(negedge clk);
    if (reset_n && mem_ld) begin
      m_a = mem_address; m_d = mem_data_out; m_mt = mem_mt; m_w = mem_wr;
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_ld actual=%h expected=none t=%0t", m_a, $time);
      end else begin
        m_e = bus_q.pop_front();
        chk("bus_addr", m_a, m_e.addr);
        chk("bus_mt", {29'd0, m_mt}, {29'd0, m_e.mt});
        chk("bus_wr", {31'd0, m_w}, {31'd0, m_e.wr});
        if (m_e.wr) chk("bus_data", m_d, m_e.data);
      end
      m_dly = $urandom_range(1, 4);
      m_len = $urandom_range(1, 3);
      m_ok  = 1'b1;
      for (int i = 0; i < m_dly && m_ok; i++) begin
        @(negedge clk);
        if (!reset_n) m_ok = 1'b0;
        else begin
          chk("ld_single", {31'd0, mem_ld}, 32'd0);
          chk("ready_low", {31'd0, req_ready}, 32'd0);
          chk("wr_hold_ack", {31'd0, mem_wr}, {31'd0, m_w});
        end
      end
      if (m_ok) mem_busy = 1'b1;
      for (int i = 0; i < m_len && m_ok; i++) begin
        @(negedge clk);
        if (!reset_n) m_ok = 1'b0;
        else begin
          chk("wr_hold_busy", {31'd0, mem_wr}, {31'd0, m_w});
          chk("addr_hold", mem_address, m_a);
        end
      end
      if (m_ok) begin
        if (m_w) begin
          case (m_mt)
            MT_B, MT_BU: bus_mem[m_a[5:2]][8 * int'(m_a[1:0]) +: 8] = m_d[8 * int'(m_a[1:0]) +: 8];
            MT_H, MT_HU: bus_mem[m_a[5:2]][16 * int'(m_a[1]) +: 16] = m_d[16 * int'(m_a[1]) +: 16];
            default:     bus_mem[m_a[5:2]] = m_d;
          endcase
          mem_data_in = $urandom;
        end else begin
          mem_data_in = bus_mem[m_a[5:2]];
        end
      end
      mem_busy = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [2:0]  r_mt;
  logic [31:0] r_a;
  bit          got;
  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 32'h8081_7F01; bus_mem[4] = 32'h8081_7F01;
    ref_mem[5] = 32'h5555_5555; bus_mem[5] = 32'h5555_5555;

    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mis", {31'd0, resp_misaligned}, 32'd0);
    chk("rst_ld_wr", {30'd0, mem_ld, mem_wr}, 32'd0);
    chk("rst_bus", mem_address | mem_data_out | {29'd0, mem_mt}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_req(1'b0, 32'h11, MT_B,  32'd0);
    do_req(1'b0, 32'h13, MT_B,  32'd0);
    do_req(1'b0, 32'h13, MT_BU, 32'd0);
    do_req(1'b0, 32'h12, MT_H,  32'd0);
    do_req(1'b0, 32'h10, MT_HU, 32'd0);
    do_req(1'b0, 32'h10, MT_W,  32'd0);
    do_req(1'b1, 32'h16, MT_H,  32'h1234_ABCD);
    do_req(1'b0, 32'h14, MT_W,  32'd0);
    do_req(1'b0, 32'h12, MT_W,  32'd0);
    do_req(1'b0, 32'h13, MT_HU, 32'd0);
    do_req(1'b1, 32'h21, 3'd7,  32'hCAFE_F00D);

    for (int n = 0; n < 150; n++) begin
      r_a  = 32'($urandom_range(0, 63));
      r_mt = 3'($urandom);
      do_req(1'($urandom), r_a, r_mt, $urandom);
    end

    // Reset during WAIT_DONE of a store: abandoned, nothing written, no response.
    wait_ready();
    bus_q.push_back('{addr: 32'h20, mt: MT_W, wr: 1'b1, data: 32'hDEAD_BEEF});
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_mt = MT_W; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      got = mem_busy;
    end
    chk("rst_busy_seen", {31'd0, got}, 32'd1);
    #2;
    chk("wr_before_rst", {31'd0, mem_wr}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_async_ld", {31'd0, mem_ld}, 32'd0);
    chk("rst_async_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_async_bus", mem_address | mem_data_out | {29'd0, mem_mt}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    do_req(1'b0, 32'h20, MT_W, 32'd0);
    do_req(1'b0, 32'h22, MT_H, 32'd0);

    repeat (4) @(negedge clk);
    chk("resp_q_empty", resp_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
